// File: rtl/Sequencer_def.sv
// Sequencer-local types: FSM states and the instruction classes that the
// decoder hands to the execute stage.
package Sequencer_def;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALTED,
        S_ERROR
    } seq_state_t;

    typedef enum logic [2:0] {
        CLS_ALU,
        CLS_MOVSET,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_HALT,
        CLS_NOP
    } inst_class_t;

    // Memory wait counter width; large enough for any timeout in 1..255.
    localparam int WAIT_W = 8;

endpackage

// File: rtl/TopLevel_def.sv
// Core-wide instruction encoding: 3-bit major opcode (instruction[8:6])
// and 2-bit function field (instruction[1:0]).
package TopLevel_def;

    typedef enum logic [2:0] {
        R_ADD = 3'd0,
        R_SHF = 3'd1,
        R_NEG = 3'd2,
        M_MOV = 3'd3,
        I_SET = 3'd4,
        I_LW  = 3'd5,
        I_SW  = 3'd6,
        B_BEQ = 3'd7
    } opcode_t;

    // R_ADD group
    localparam logic [1:0] FUN_ADD  = 2'd0;
    localparam logic [1:0] FUN_ADDC = 2'd1;
    localparam logic [1:0] FUN_SUB  = 2'd2;
    localparam logic [1:0] FUN_LWR  = 2'd3;
    // R_SHF group (codes 2 and 3 are reserved)
    localparam logic [1:0] FUN_SLL  = 2'd0;
    localparam logic [1:0] FUN_SRA  = 2'd1;
    // R_NEG group
    localparam logic [1:0] FUN_NEG  = 2'd0;
    localparam logic [1:0] FUN_AND  = 2'd1;
    localparam logic [1:0] FUN_OR   = 2'd2;
    localparam logic [1:0] FUN_HALT = 2'd3;

endpackage

// File: rtl/seq_decode.sv
// Combinational instruction classifier: opcode/funct -> execution class.
module seq_decode
    import TopLevel_def::*;
    import Sequencer_def::*;
(
    input  logic [2:0]  opcode,
    input  logic [1:0]  funct,
    output inst_class_t inst_class
);

    // Map every opcode/funct pair to the class that steers EXEC.
    always_comb begin
        inst_class = CLS_NOP;
        case (opcode)
            R_ADD: inst_class = (funct == FUN_LWR) ? CLS_LOAD : CLS_ALU;
            R_SHF: inst_class = (funct == FUN_SLL || funct == FUN_SRA) ? CLS_ALU : CLS_NOP;
            R_NEG: inst_class = (funct == FUN_HALT) ? CLS_HALT : CLS_ALU;
            M_MOV: inst_class = CLS_MOVSET;
            I_SET: inst_class = CLS_MOVSET;
            I_LW:  inst_class = CLS_LOAD;
            I_SW:  inst_class = CLS_STORE;
            B_BEQ: inst_class = CLS_BRANCH;
        endcase
    end

endmodule

// File: rtl/exec_sequencer.sv
// Multi-cycle control sequencer for the 9-bit core: fetch/decode/exec/
// mem/wb stepping, datapath strobes, halt/error handling and counters.
module exec_sequencer
    import TopLevel_def::*;
    import Sequencer_def::*;
#(
    parameter int CW          = 16,
    parameter int MEM_TIMEOUT = 15
)(
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [2:0]    opcode,
    input  logic [1:0]    funct,
    input  logic          take_branch,
    input  logic          mem_ack,
    output logic          ir_load,
    output logic          pc_load_en,
    output logic          pc_branch_sel,
    output logic          carry_en,
    output logic          mem_req,
    output logic          mem_we,
    output logic          reg_write_en,
    output logic          busy,
    output logic          halt,
    output logic          timeout_err,
    output logic [CW-1:0] cycle_ct,
    output logic [CW-1:0] inst_ct
);

    // Last wait-counter value tolerated before the access is abandoned.
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    seq_state_t        state_reg, state_next;
    inst_class_t       class_reg, class_dec;
    logic [WAIT_W-1:0] wait_reg;
    logic [CW-1:0]     cycle_ct_reg, inst_ct_reg;
    logic              retire;

    seq_decode u_decode (
        .opcode     (opcode),
        .funct      (funct),
        .inst_class (class_dec)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_reg <= S_IDLE;
        else       state_reg <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE, S_HALTED, S_ERROR: if (start) state_next = S_FETCH;
            S_FETCH:  state_next = S_DECODE;
            S_DECODE: state_next = S_EXEC;
            S_EXEC: begin
                case (class_reg)
                    CLS_ALU, CLS_MOVSET:  state_next = S_WB;
                    CLS_LOAD, CLS_STORE:  state_next = S_MEM;
                    CLS_HALT:             state_next = S_HALTED;
                    default:              state_next = S_FETCH;
                endcase
            end
            S_MEM: begin
                if (mem_ack)
                    state_next = (class_reg == CLS_STORE) ? S_FETCH : S_WB;
                else if (wait_reg == WAIT_LAST)
                    state_next = S_ERROR;
            end
            S_WB:     state_next = S_FETCH;
            default:  state_next = S_IDLE;
        endcase
    end

    // Output strobes and retirement, decoded from the current state.
    always_comb begin
        ir_load       = 1'b0;
        pc_load_en    = 1'b0;
        pc_branch_sel = 1'b0;
        carry_en      = 1'b0;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        reg_write_en  = 1'b0;
        retire        = 1'b0;
        case (state_reg)
            S_FETCH: ir_load = 1'b1;
            S_EXEC: begin
                case (class_reg)
                    CLS_ALU: carry_en = 1'b1;
                    CLS_BRANCH: begin
                        pc_load_en    = 1'b1;
                        pc_branch_sel = take_branch;
                        retire        = 1'b1;
                    end
                    CLS_HALT: retire = 1'b1;
                    CLS_NOP: begin
                        pc_load_en = 1'b1;
                        retire     = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = (class_reg == CLS_STORE);
                // A store has nothing to write back, so it retires on ack.
                if (mem_ack && class_reg == CLS_STORE) begin
                    pc_load_en = 1'b1;
                    retire     = 1'b1;
                end
            end
            S_WB: begin
                reg_write_en = 1'b1;
                pc_load_en   = 1'b1;
                retire       = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy        = !(state_reg == S_IDLE || state_reg == S_HALTED || state_reg == S_ERROR);
    assign halt        = (state_reg == S_HALTED);
    assign timeout_err = (state_reg == S_ERROR);
    assign cycle_ct    = cycle_ct_reg;
    assign inst_ct     = inst_ct_reg;

    // Capture the instruction class while the IR is stable in DECODE.
    always_ff @(posedge clk) begin
        if (reset)                      class_reg <= CLS_NOP;
        else if (state_reg == S_DECODE) class_reg <= class_dec;
    end

    // Memory wait counter: armed in EXEC, advanced on each un-acked MEM cycle.
    always_ff @(posedge clk) begin
        if (reset)
            wait_reg <= '0;
        else if (state_reg == S_EXEC)
            wait_reg <= '0;
        else if (state_reg == S_MEM && !mem_ack)
            wait_reg <= wait_reg + WAIT_W'(1);
    end

    // Saturating cycle and retired-instruction counters, cleared on restart.
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_ct_reg <= '0;
            inst_ct_reg  <= '0;
        end else if (start && !busy) begin
            cycle_ct_reg <= '0;
            inst_ct_reg  <= '0;
        end else begin
            if (busy && cycle_ct_reg != '1)
                cycle_ct_reg <= cycle_ct_reg + CW'(1);
            if (retire && inst_ct_reg != '1)
                inst_ct_reg <= inst_ct_reg + CW'(1);
        end
    end

endmodule

// File: tb/tb_exec_sequencer.sv
// Self-checking bench for exec_sequencer and its standalone decoder.
module tb_exec_sequencer;
    import TopLevel_def::*;
    import Sequencer_def::*;

    logic        clk = 1'b0;
    logic        reset, start, take_branch, mem_ack;
    logic [2:0]  opcode;
    logic [1:0]  funct;
    logic        ir_load, pc_load_en, pc_branch_sel, carry_en, mem_req, mem_we;
    logic        reg_write_en, busy, halt, timeout_err;
    logic [15:0] cycle_ct, inst_ct;
    logic        d4_ir_load, d4_pc_load_en, d4_pc_branch_sel, d4_carry_en, d4_mem_req, d4_mem_we;
    logic        d4_reg_write_en, d4_busy, d4_halt, d4_timeout_err;
    logic [3:0]  d4_cycle_ct, d4_inst_ct;
    logic [2:0]  dec_op;
    logic [1:0]  dec_fn;
    inst_class_t dec_class;

    always #5 clk = ~clk;

    exec_sequencer #(.CW(16), .MEM_TIMEOUT(15)) dut (
        .clk(clk), .reset(reset), .start(start), .opcode(opcode), .funct(funct),
        .take_branch(take_branch), .mem_ack(mem_ack), .ir_load(ir_load),
        .pc_load_en(pc_load_en), .pc_branch_sel(pc_branch_sel), .carry_en(carry_en),
        .mem_req(mem_req), .mem_we(mem_we), .reg_write_en(reg_write_en), .busy(busy),
        .halt(halt), .timeout_err(timeout_err), .cycle_ct(cycle_ct), .inst_ct(inst_ct)
    );

    exec_sequencer #(.CW(4), .MEM_TIMEOUT(15)) dut4 (
        .clk(clk), .reset(reset), .start(start), .opcode(opcode), .funct(funct),
        .take_branch(take_branch), .mem_ack(mem_ack), .ir_load(d4_ir_load),
        .pc_load_en(d4_pc_load_en), .pc_branch_sel(d4_pc_branch_sel), .carry_en(d4_carry_en),
        .mem_req(d4_mem_req), .mem_we(d4_mem_we), .reg_write_en(d4_reg_write_en), .busy(d4_busy),
        .halt(d4_halt), .timeout_err(d4_timeout_err), .cycle_ct(d4_cycle_ct), .inst_ct(d4_inst_ct)
    );

    seq_decode u_dec (.opcode(dec_op), .funct(dec_fn), .inst_class(dec_class));

    typedef struct {
        logic [2:0] op;
        logic [1:0] fn;
        logic       tb;
        int         w;     // wait cycles before ack (>=15 means never)
        logic       st;    // hold start high throughout the instruction
        int         lat, rw, cy, mr, mw, pl;
        logic       sel;
        int         fin;   // 0 next FETCH, 1 HALTED, 2 ERROR
        int         ret;   // instructions retired
    } inst_vec_t;

    typedef struct {
        logic [2:0]  op;
        logic [1:0]  fn;
        inst_class_t cls;
    } dec_vec_t;

    inst_class_t cls_tab [8][4];
    dec_vec_t    dec_tab [32];
    inst_vec_t   dir_tab [12];
    int          checks = 0;
    int          errors = 0;
    int          exp_inst = 0;
    int          exp_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic inst_vec_t mk(logic [2:0] op, logic [1:0] fn, logic tb, int w, logic st,
                                     int lat, int rw, int cy, int mr, int mw, int pl,
                                     logic sel, int fin, int ret);
        inst_vec_t v;
        v.op = op; v.fn = fn; v.tb = tb; v.w = w; v.st = st;
        v.lat = lat; v.rw = rw; v.cy = cy; v.mr = mr; v.mw = mw; v.pl = pl;
        v.sel = sel; v.fin = fin; v.ret = ret;
        return v;
    endfunction

    // Reference model: per-class cost and strobe counts of one instruction.
    function automatic inst_vec_t model(logic [2:0] op, logic [1:0] fn, logic tb, int w);
        case (cls_tab[op][fn])
            CLS_ALU:    return mk(op, fn, tb, w, 1'b0, 4,     1, 1, 0,     0,     1, 1'b0, 0, 1);
            CLS_MOVSET: return mk(op, fn, tb, w, 1'b0, 4,     1, 0, 0,     0,     1, 1'b0, 0, 1);
            CLS_LOAD:   return mk(op, fn, tb, w, 1'b0, 5 + w, 1, 0, w + 1, 0,     1, 1'b0, 0, 1);
            CLS_STORE:  return mk(op, fn, tb, w, 1'b0, 4 + w, 0, 0, w + 1, w + 1, 1, 1'b0, 0, 1);
            CLS_BRANCH: return mk(op, fn, tb, w, 1'b0, 3,     0, 0, 0,     0,     1, tb,   0, 1);
            CLS_HALT:   return mk(op, fn, tb, w, 1'b0, 3,     0, 0, 0,     0,     0, 1'b0, 1, 1);
            default:    return mk(op, fn, tb, w, 1'b0, 3,     0, 0, 0,     0,     1, 1'b0, 0, 1);
        endcase
    endfunction

    // Run one instruction starting in its FETCH cycle and score it.
    task automatic run_inst(input inst_vec_t v, input string tag);
        int   lat, rw, cy, mr, mw, pl, excl;
        logic sel;
        bit   done;
        lat = 0; rw = 0; cy = 0; mr = 0; mw = 0; pl = 0; excl = 0; sel = 1'b0; done = 0;
        opcode = v.op; funct = v.fn; take_branch = v.tb; start = v.st;
        for (int k = 0; k < 40 && !done; k++) begin
            mem_ack = 1'b0;
            if (mem_req) begin
                mr++;
                mem_ack = (mr == v.w + 1);
            end
            #1;
            lat++;
            if (reg_write_en) rw++;
            if (carry_en) cy++;
            if (mem_we) mw++;
            if (pc_load_en) begin
                pl++;
                sel = pc_branch_sel;
            end
            if ((int'(ir_load) + int'(reg_write_en) + int'(mem_req) > 1) || (pc_load_en && ir_load))
                excl++;
            step();
            if (ir_load || halt || timeout_err) done = 1;
        end
        mem_ack = 1'b0;
        start = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s bound: no FETCH/HALTED/ERROR within 40 cycles", tag);
        end
        exp_inst += v.ret;
        exp_cyc  += v.lat;
        check({tag, " latency"}, lat, v.lat);
        check({tag, " reg_write cycles"}, rw, v.rw);
        check({tag, " carry cycles"}, cy, v.cy);
        check({tag, " mem_req cycles"}, mr, v.mr);
        check({tag, " mem_we cycles"}, mw, v.mw);
        check({tag, " pc_load cycles"}, pl, v.pl);
        check({tag, " branch_sel"}, sel, v.sel);
        check({tag, " strobe overlap"}, excl, 0);
        case (v.fin)
            0:       check({tag, " next ir_load"}, ir_load, 1);
            1:       check({tag, " halt"}, halt, 1);
            default: check({tag, " timeout_err"}, timeout_err, 1);
        endcase
        check({tag, " inst_ct"}, inst_ct, exp_inst);
        check({tag, " cycle_ct"}, cycle_ct, exp_cyc);
        $display("inst %s op=%0d fn=%0d tb=%0d w=%0d lat=%0d inst_ct=%0d cycle_ct=%0d",
                 tag, v.op, v.fn, v.tb, v.w, lat, inst_ct, cycle_ct);
    endtask

    task automatic do_start(input string tag);
        start = 1'b1;
        step();
        start = 1'b0;
        exp_inst = 0;
        exp_cyc = 0;
        check({tag, " ir_load"}, ir_load, 1);
        check({tag, " cycle_ct cleared"}, cycle_ct, 0);
        check({tag, " inst_ct cleared"}, inst_ct, 0);
        check({tag, " flags cleared"}, {halt, timeout_err}, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; start = 1'b0; take_branch = 1'b0; mem_ack = 1'b0;
        opcode = 3'd0; funct = 2'd0; dec_op = 3'd0; dec_fn = 2'd0;

        // Class per opcode, indexed by funct 0..3.
        cls_tab[R_ADD] = '{CLS_ALU,    CLS_ALU,    CLS_ALU,    CLS_LOAD};
        cls_tab[R_SHF] = '{CLS_ALU,    CLS_ALU,    CLS_NOP,    CLS_NOP};
        cls_tab[R_NEG] = '{CLS_ALU,    CLS_ALU,    CLS_ALU,    CLS_HALT};
        cls_tab[M_MOV] = '{CLS_MOVSET, CLS_MOVSET, CLS_MOVSET, CLS_MOVSET};
        cls_tab[I_SET] = '{CLS_MOVSET, CLS_MOVSET, CLS_MOVSET, CLS_MOVSET};
        cls_tab[I_LW]  = '{CLS_LOAD,   CLS_LOAD,   CLS_LOAD,   CLS_LOAD};
        cls_tab[I_SW]  = '{CLS_STORE,  CLS_STORE,  CLS_STORE,  CLS_STORE};
        cls_tab[B_BEQ] = '{CLS_BRANCH, CLS_BRANCH, CLS_BRANCH, CLS_BRANCH};
        for (int i = 0; i < 32; i++) begin
            dec_tab[i].op  = 3'(i >> 2);
            dec_tab[i].fn  = 2'(i);
            dec_tab[i].cls = cls_tab[i >> 2][i & 3];
        end

        //                   op     fn        tb   w  st   lat rw cy mr mw pl sel  fin ret
        dir_tab[0]  = mk(R_ADD, FUN_ADD,  1'b0, 0, 1'b0, 4, 1, 1, 0, 0, 1, 1'b0, 0, 1);
        dir_tab[1]  = mk(B_BEQ, 2'd0,     1'b1, 0, 1'b0, 3, 0, 0, 0, 0, 1, 1'b1, 0, 1);
        dir_tab[2]  = mk(B_BEQ, 2'd0,     1'b0, 0, 1'b0, 3, 0, 0, 0, 0, 1, 1'b0, 0, 1);
        dir_tab[3]  = mk(I_LW,  2'd0,     1'b0, 3, 1'b0, 8, 1, 0, 4, 0, 1, 1'b0, 0, 1);
        dir_tab[4]  = mk(I_SW,  2'd0,     1'b0, 0, 1'b0, 4, 0, 0, 1, 1, 1, 1'b0, 0, 1);
        dir_tab[5]  = mk(I_SET, 2'd1,     1'b0, 0, 1'b0, 4, 1, 0, 0, 0, 1, 1'b0, 0, 1);
        dir_tab[6]  = mk(R_SHF, 2'd2,     1'b1, 0, 1'b0, 3, 0, 0, 0, 0, 1, 1'b0, 0, 1);
        dir_tab[7]  = mk(R_ADD, FUN_LWR,  1'b0, 1, 1'b0, 6, 1, 0, 2, 0, 1, 1'b0, 0, 1);
        dir_tab[8]  = mk(R_NEG, FUN_OR,   1'b0, 0, 1'b0, 4, 1, 1, 0, 0, 1, 1'b0, 0, 1);
        dir_tab[9]  = mk(I_SW,  2'd3,     1'b1, 2, 1'b0, 6, 0, 0, 3, 3, 1, 1'b0, 0, 1);
        dir_tab[10] = mk(M_MOV, 2'd0,     1'b0, 0, 1'b1, 4, 1, 0, 0, 0, 1, 1'b0, 0, 1);
        dir_tab[11] = mk(R_SHF, FUN_SRA,  1'b0, 0, 1'b0, 4, 1, 1, 0, 0, 1, 1'b0, 0, 1);

        // Standalone decoder over all opcode/funct pairs.
        for (int i = 0; i < 32; i++) begin
            dec_op = dec_tab[i].op;
            dec_fn = dec_tab[i].fn;
            #1;
            check($sformatf("decode op=%0d fn=%0d", dec_op, dec_fn), dec_class, dec_tab[i].cls);
        end

        // Reset for two cycles; everything must read zero.
        repeat (2) step();
        check("reset outputs", {ir_load, pc_load_en, pc_branch_sel, carry_en, mem_req, mem_we,
                                reg_write_en, busy, halt, timeout_err}, 0);
        check("reset counters", {cycle_ct, inst_ct}, 0);
        check("reset outputs cw4", {d4_ir_load, d4_pc_load_en, d4_pc_branch_sel, d4_carry_en,
                                    d4_mem_req, d4_mem_we, d4_reg_write_en, d4_busy, d4_halt,
                                    d4_timeout_err, d4_cycle_ct, d4_inst_ct}, 0);
        reset = 1'b0;
        step();
        check("idle without start", busy, 0);
        do_start("first start");

        // Directed instruction vectors.
        for (int i = 0; i < 12; i++)
            run_inst(dir_tab[i], $sformatf("dir%0d", i));

        // Memory never acknowledges: 15 MEM cycles then ERROR.
        run_inst(mk(I_LW, 2'd0, 1'b0, 255, 1'b0, 18, 0, 0, 15, 0, 0, 1'b0, 2, 0), "timeout");
        check("timeout busy", busy, 0);
        check("timeout mem_req", mem_req, 0);
        step();
        check("error sticky", timeout_err, 1);
        do_start("restart from error");

        // Three ALU instructions then HALT; start while busy is ignored.
        run_inst(model(R_ADD, FUN_ADDC, 1'b0, 0), "alu1");
        begin
            inst_vec_t v;
            v = model(R_NEG, FUN_AND, 1'b0, 0);
            v.st = 1'b1;
            run_inst(v, "alu2 start-ignored");
        end
        run_inst(model(R_SHF, FUN_SLL, 1'b0, 0), "alu3");
        run_inst(model(R_NEG, FUN_HALT, 1'b0, 0), "halt");
        check("halt inst_ct", inst_ct, 4);
        check("halt cycle_ct", cycle_ct, 15);
        repeat (3) step();
        check("halted frozen cycle_ct", cycle_ct, 15);
        check("halted busy", {busy, halt}, 2'b01);
        do_start("restart from halt");

        // Randomized instruction stream against the model.
        for (int i = 0; i < 60; i++) begin
            logic [2:0] op;
            logic [1:0] fn;
            logic       tb;
            int         w;
            op = 3'($urandom_range(0, 7));
            fn = 2'($urandom_range(0, 3));
            tb = 1'($urandom_range(0, 1));
            w  = $urandom_range(0, 4);
            run_inst(model(op, fn, tb, w), $sformatf("rnd%0d", i));
            if (cls_tab[op][fn] == CLS_HALT) do_start("random restart");
        end

        // Reset in the middle of a memory wait.
        opcode = I_LW; funct = 2'd0;
        repeat (3) step();
        check("mid-mem mem_req", mem_req, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid-mem reset outputs", {ir_load, pc_load_en, pc_branch_sel, carry_en, mem_req,
                                        mem_we, reg_write_en, busy, halt, timeout_err}, 0);
        check("mid-mem reset counters", {cycle_ct, inst_ct}, 0);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        check("stray ack in idle", busy, 0);
        do_start("start after reset");

        // Twenty ALU instructions: 4-bit counters must pin at 15.
        for (int i = 0; i < 20; i++)
            run_inst(model(R_ADD, FUN_SUB, 1'b0, 0), $sformatf("sat%0d", i));
        check("cw4 cycle_ct saturated", d4_cycle_ct, 15);
        check("cw4 inst_ct saturated", d4_inst_ct, 15);
        check("cw16 cycle_ct", cycle_ct, 80);
        check("cw16 inst_ct", inst_ct, 20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
